// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC CPU: opcodes, branch conditions, fetch FSM states.
// Used by the fetch stage and the branch-condition evaluator.
package wisc_pkg;

    localparam logic [3:0] OP_B   = 4'hC;
    localparam logic [3:0] OP_BR  = 4'hD;
    localparam logic [3:0] OP_PCS = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        COND_NE     = 3'b000,
        COND_EQ     = 3'b001,
        COND_GT     = 3'b010,
        COND_LT     = 3'b011,
        COND_GE     = 3'b100,
        COND_LE     = 3'b101,
        COND_OVFL   = 3'b110,
        COND_UNCOND = 3'b111
    } cond_t;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StFetch  = 2'd1,
        StIssue  = 2'd2,
        StHalted = 2'd3
    } fetch_state_t;

    // Byte offset of a B instruction: sign-extended word immediate times two.
    function automatic logic [15:0] branch_offset(logic [8:0] imm9);
        return {{6{imm9[8]}}, imm9, 1'b0};
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch-condition evaluator: decides whether a ccc condition holds
// for the current Z/N/V flags.
module branch_cond_eval
    import wisc_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic       z,
    input  logic       n,
    input  logic       v,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        unique case (cond_t'(ccc))
            COND_NE:     taken = ~z;
            COND_EQ:     taken = z;
            COND_GT:     taken = ~z & ~n;
            COND_LT:     taken = n;
            COND_GE:     taken = z | (~z & ~n);
            COND_LE:     taken = n | z;
            COND_OVFL:   taken = v;
            COND_UNCOND: taken = 1'b1;
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// WISC fetch stage: owns the PC, fetches over req/ack and issues to decode over valid/ready.
// Optional build macro FETCH_PERF_CNT_EN adds saturating retired/taken counters.
module fetch_unit
    import wisc_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
`ifdef FETCH_PERF_CNT_EN
    ,
    parameter int unsigned PERF_W   = 16
`endif
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        flag_z,
    input  logic        flag_n,
    input  logic        flag_v,
    output logic [3:0]  br_rs,
    input  logic [15:0] br_rs_data,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2,
    output logic        hlt
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] retired_cnt,
    output logic [PERF_W-1:0] taken_cnt
`endif
);

    fetch_state_t state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  inst_q, inst_d;
    logic [3:0]   opcode;
    logic         cond_true;
    logic         accept;
    logic         branch_taken;

    assign opcode = inst_q[15:12];

    branch_cond_eval u_branch_cond_eval (
        .ccc   (inst_q[11:9]),
        .z     (flag_z),
        .n     (flag_n),
        .v     (flag_v),
        .taken (cond_true)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            inst_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    // IDLE also serves as the PC-update slot after each accepted instruction,
    // giving the three-cycle minimum per instruction.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   state_d = StFetch;
            StFetch:  if (imem_ack) state_d = StIssue;
            StIssue:  if (inst_ready) state_d = (opcode == OP_HLT) ? StHalted : StIdle;
            StHalted: state_d = StHalted;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        accept       = (state_q == StIssue) & inst_ready;
        branch_taken = ((opcode == OP_B) | (opcode == OP_BR)) & cond_true;
        pc_plus2     = pc_q + 16'd2;
        pc_d         = pc_q;
        inst_d       = inst_q;
        if ((state_q == StFetch) && imem_ack) begin
            inst_d = imem_rdata;
        end
        if (accept) begin
            unique case (opcode)
                OP_B:    pc_d = cond_true ? pc_plus2 + branch_offset(inst_q[8:0]) : pc_plus2;
                OP_BR:   pc_d = cond_true ? (br_rs_data & 16'hFFFE) : pc_plus2;
                OP_HLT:  pc_d = pc_q;
                // PCS only writes pc+2 back; for fetch it is sequential.
                OP_PCS:  pc_d = pc_plus2;
                default: pc_d = pc_plus2;
            endcase
        end
    end

    always_comb begin
        imem_req   = (state_q == StFetch);
        inst_valid = (state_q == StIssue);
        hlt        = (state_q == StHalted);
        imem_addr  = pc_q;
        pc         = pc_q;
        inst       = inst_q;
        br_rs      = inst_q[7:4];
    end

`ifdef FETCH_PERF_CNT_EN
    logic [PERF_W-1:0] retired_q, taken_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= '0;
            taken_q   <= '0;
        end else if (accept) begin
            if (~&retired_q) retired_q <= retired_q + 1'b1;
            if (branch_taken && ~&taken_q) taken_q <= taken_q + 1'b1;
        end
    end

    assign retired_cnt = retired_q;
    assign taken_cnt   = taken_q;
`endif

endmodule
